// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage for the MIPS core.
//
// Holds the PC, requests one word at a time from instruction memory over a
// req/ready handshake, presents the fetched word to decode, and on retire
// picks the next PC from JumpReg > Jump > taken Branch > sequential.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   o_imem_req/o_imem_addr fetch request and word address (held until ready)
//   i_imem_ready/i_imem_rdata  accept strobe and returned word
//   o_instr/o_instr_valid  held instruction and its live flag
//   o_pc, o_link_addr      address of o_instr and o_pc+4 (JAL write data)
//   i_stall                datapath not ready to retire o_instr
//   i_jump, i_branch, i_jump_reg, i_branch_cond, i_reg_target
//                          next-PC controls, sampled on the retire cycle only
//   o_fetch_err            sticky misaligned-target flag
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned JR targets
// into the ERR state; otherwise target bits [1:0] are silently cleared.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_link_addr,
  input  logic        i_stall,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_jump_reg,
  input  logic        i_branch_cond,
  input  logic [31:0] i_reg_target,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_started;
  logic [31:0] w_seq, w_jmp_tgt, w_br_tgt, w_next_pc;

  // Target arithmetic wraps modulo 2^32 by construction.
  assign w_seq     = r_pc + 32'd4;
  assign w_jmp_tgt = {w_seq[31:28], r_instr[25:0], 2'b00};
  assign w_br_tgt  = w_seq + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_seq;
    if (i_jump_reg)                   w_next_pc = i_reg_target;
    else if (i_jump)                  w_next_pc = w_jmp_tgt;
    else if (i_branch && i_branch_cond) w_next_pc = w_br_tgt;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err, w_err_nxt;
  assign o_fetch_err = r_err;
`else
  assign o_fetch_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
`ifdef FETCH_ALIGN_CHECK_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      // r_started gives one full IDLE cycle after reset release.
      IDLE:  if (r_started) w_state_nxt = FETCH;
      FETCH: if (i_imem_ready) begin
        w_instr_nxt = i_imem_rdata;
        w_state_nxt = HOLD;
      end
      HOLD: if (!i_stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (w_next_pc[1:0] != 2'b00) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ERR;
        end else begin
          w_pc_nxt    = w_next_pc;
          w_state_nxt = FETCH;
        end
`else
        w_pc_nxt    = w_next_pc & 32'hFFFF_FFFC;
        w_state_nxt = FETCH;
`endif
      end
      ERR: w_state_nxt = ERR;  // only reset leaves
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_started <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_started <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      r_err     <= w_err_nxt;
`endif
    end
  end

  assign o_imem_req    = (r_state == FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == HOLD);
  assign o_pc          = r_pc;
  assign o_link_addr   = w_seq;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset/sequential, wait states + stall, a table of
// next-PC vectors, misaligned JR and reset in the middle of a fetch.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_ready, instr_valid, stall;
  logic        jump, branch, jump_reg, branch_cond, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc, link_addr, reg_target;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata), .o_instr(instr),
    .o_instr_valid(instr_valid), .o_pc(pc), .o_link_addr(link_addr),
    .i_stall(stall), .i_jump(jump), .i_branch(branch), .i_jump_reg(jump_reg),
    .i_branch_cond(branch_cond), .i_reg_target(reg_target), .o_fetch_err(fetch_err));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        j, b, jr, cond;
    logic [31:0] rt;
    logic [31:0] nxt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_pc"}, pc, RPC);
    chk({tag, "_link"}, link_addr, RPC + 32'd4);
    chk({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
  endtask

  // Wait (bounded) for a request, then compare its address with the scoreboard.
  task automatic wait_req(input string tag);
    logic [31:0] e;
    for (int n = 0; n < 20 && !imem_req; n++) @(negedge clk);
    chk({tag, "_req_seen"}, {31'b0, imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard_empty actual=%h required=none", tag, imem_addr);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, imem_addr, e);
    end
  endtask

  // Full fetch: request, `waits` cycles of no-ready, then deliver `word`.
  task automatic fetch(input string tag, input logic [31:0] word, input int waits);
    logic [31:0] a;
    wait_req(tag);
    a = imem_addr;
    chk({tag, "_valid_in_fetch"}, {31'b0, instr_valid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk({tag, "_addr_stable"}, imem_addr, a);
      chk({tag, "_req_held"}, {31'b0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_req_low"}, {31'b0, imem_req}, 32'd0);
  endtask

  task automatic retire(input string tag, input logic j, input logic b, input logic jr,
                        input logic c, input logic [31:0] rt, input logic [31:0] nxt,
                        input logic push);
    jump = j; branch = b; jump_reg = jr; branch_cond = c; reg_target = rt; stall = 1'b0;
    if (push) exp_q.push_back(nxt);
    @(negedge clk);
    jump = 0; branch = 0; jump_reg = 0; branch_cond = 0; reg_target = $urandom;
    chk({tag, "_retired"}, {31'b0, instr_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RPC);
  endtask

  vec_t vecs[8];
  logic [31:0] pc_before;

  initial begin
    rst_n = 0; imem_ready = 0; imem_rdata = 0; stall = 0;
    jump = 0; branch = 0; jump_reg = 0; branch_cond = 0; reg_target = 0;

    vecs[0] = '{32'h0040_0010, 32'h1000_FFFC, 0, 1, 0, 1, 32'h0, 32'h0040_0004}; // BEQ taken back
    vecs[1] = '{32'h0040_0010, 32'h1000_FFFC, 0, 1, 0, 0, 32'h0, 32'h0040_0014}; // BEQ not taken
    vecs[2] = '{32'h0040_0020, 32'h0810_0040, 1, 0, 0, 0, 32'h0, 32'h0040_0100}; // J
    vecs[3] = '{32'h0040_0020, 32'h0C10_0040, 1, 0, 0, 0, 32'h0, 32'h0040_0100}; // JAL
    vecs[4] = '{32'h0040_0030, 32'h03E0_0008, 1, 0, 1, 0, 32'h0040_0200, 32'h0040_0200}; // JR beats J
    vecs[5] = '{32'h0040_0040, 32'h1000_0003, 0, 1, 0, 1, 32'h0, 32'h0040_0050}; // BEQ fwd
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 32'h0, 32'h0000_0000}; // seq wrap
    vecs[7] = '{32'hF000_0000, 32'h0BFF_FFFF, 1, 0, 0, 0, 32'h0, 32'hFFFF_FFFC}; // J region top

    // Reset, one IDLE cycle, request on the 2nd edge, sequential fetches.
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("idle_after_release_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("req_on_2nd_edge", {31'b0, imem_req}, 32'd1);
    fetch("seq0", 32'h2402_0001, 0);
    retire("seq0", 0, 0, 0, 0, 0, RPC + 4, 1);
    fetch("seq1", 32'h2402_0002, 0);
    retire("seq1", 0, 0, 0, 0, 0, RPC + 8, 1);
    fetch("seq2", 32'h2402_0003, 3);  // wait states

    // Stall for 4 cycles; a stray ready in HOLD must be ignored.
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      imem_ready = (s == 1);
      imem_rdata = 32'hBAD0_0000 + s;
      @(negedge clk);
      chk("stall_instr", instr, 32'h2402_0003);
      chk("stall_pc", pc, RPC + 8);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0;
    retire("stall_rel", 0, 0, 0, 0, 0, RPC + 12, 1);

    // Table of next-PC vectors; each reached via a JR to its PC.
    foreach (vecs[i]) begin
      fetch("setup", 32'h0000_0000, 0);
      retire("setup", 0, 0, 1, 0, vecs[i].pc, vecs[i].pc, 1);
      fetch($sformatf("vec%0d", i), vecs[i].ins, i % 2);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_link", i), link_addr, vecs[i].pc + 32'd4);
      retire($sformatf("vec%0d", i), vecs[i].j, vecs[i].b, vecs[i].jr, vecs[i].cond,
             vecs[i].rt, vecs[i].nxt, 1);
    end

    // Misaligned JR target.
    fetch("mis_setup", 32'h0000_0000, 0);
    pc_before = pc;
`ifdef FETCH_ALIGN_CHECK_EN
    retire("mis", 0, 0, 1, 0, 32'h0040_0202, 32'h0, 0);
    repeat (3) begin
      chk("mis_err", {31'b0, fetch_err}, 32'd1);
      chk("mis_req", {31'b0, imem_req}, 32'd0);
      chk("mis_pc", pc, pc_before);
      @(negedge clk);
    end
`else
    retire("mis", 0, 0, 1, 0, 32'h0040_0202, 32'h0040_0200, 1);
    chk("mis_err_tied", {31'b0, fetch_err}, 32'd0);
    fetch("mis_fetch", 32'h0000_0000, 0);
    chk("mis_pc_before", pc_before, 32'hFFFF_FFFC);
`endif

    // Reset while a request is outstanding, with ready pulsing in reset.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    wait_req("midrst");
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_reset_outputs("midrst1");
    @(negedge clk);
    check_reset_outputs("midrst2");
    imem_ready = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(RPC);
    @(negedge clk);
    chk("midrst_idle", {31'b0, imem_req}, 32'd0);
    fetch("post_rst", 32'h2402_0009, 0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core. Holds the program counter, issues word requests to instruction memory over a req/ready handshake, and presents the fetched word on `instr` to the control decoder and datapath. Once the current instruction retires, it selects the next PC from the decoder's Jump/Branch/JumpReg outputs plus the branch condition and register target from the datapath.

## Interface
- `RESET_PC`, 32'h0040_0000: PC loaded on reset (start of the text segment).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of the request; bits [1:0] are always 00.
- `imem_ready`  in  1  memory accepted the request; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  instruction word returned by memory.
- `instr`  out  32  held instruction; drives the decoder's `instr` input.
- `instr_valid`  out  1  `instr` is a live, fetched instruction.
- `pc`  out  32  address of `instr`.
- `link_addr`  out  32  `pc`+4; write data for JAL.
- `stall`  in  1  datapath not ready to retire `instr`.
- `Jump`, `Branch`, `JumpReg`  in  1 each  decoder outputs for `instr`.
- `branch_cond`  in  1  datapath branch outcome (BEQ equal / BNE not-equal already resolved).
- `reg_target`  in  32  rs value for JR.
- `fetch_err`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- FSM states: IDLE, FETCH, HOLD, ERR.
- IDLE: entered on reset. Next cycle → FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ready`.
  - On `imem_ready`: `instr`←`imem_rdata` and → HOLD.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - Retire when `stall`=0: `pc`←next_pc, `instr_valid`←0, → FETCH.
  - `stall`=1 holds every output unchanged.
- next_pc priority, evaluated in the retire cycle:
  1. `JumpReg` → `reg_target`.
  2. `Jump` → {seq[31:28], instr[25:0], 2'b00}.
  3. `Branch`&&`branch_cond` → seq + (sign_ext(instr[15:0])<<2).
  4. Otherwise → seq.
  - seq = `pc`+4.
- All address arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- No delay slot: the instruction after a taken branch or jump is never fetched.
- `Branch` with `branch_cond`=0 falls through to seq.
- `imem_ready` outside FETCH is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0 (NOP), `instr_valid`=0, `pc`=`RESET_PC`, `link_addr`=`RESET_PC`+4, `fetch_err`=0; state=IDLE.
- After `rst_n` rises: one IDLE cycle, then `imem_req` rises on the 2nd edge.
- Fetch latency: `instr_valid` rises on the edge that samples `imem_ready`=1.
- Best-case throughput: one instruction per 2 cycles (ready in the first FETCH cycle, no stall).
- Control inputs, `branch_cond` and `reg_target` are sampled only in HOLD with `stall`=0. They must be combinationally derived from `instr` in that cycle.
- `rst_n`=0 mid-FETCH: the request is dropped the next cycle, and a late `imem_ready` is ignored. Memory must tolerate an abandoned request.
- `stall` is ignored outside HOLD.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A retire whose next_pc[1:0]≠00 (only possible via JR) sets `fetch_err`=1 and moves to ERR.
  - `pc` is not updated and no further requests are issued.
  - ERR exits only by reset.
- Not defined: next_pc[1:0] is forced to 00, `fetch_err` is tied 0, and ERR is unreachable.

## Test plan
- Reset/sequential: `rst_n` low 2 cycles then high; memory ready with 0 wait → `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008; `imem_req` first high 2 edges after release; `instr_valid` every other cycle.
- Wait states + stall: `imem_ready` delayed 3 cycles with `imem_addr` stable throughout; then `stall`=1 for 4 cycles → `instr`/`pc` frozen; on release, `pc` advances by 4.
- Branches:
  - BEQ at 0x00400010, imm=0xFFFC, Branch=1, branch_cond=1 → next `imem_addr`=0x00400004.
  - Same with branch_cond=0 → 0x00400014.
- Jumps:
  - J at 0x00400020, instr[25:0]=0x0100040 → next 0x00400100.
  - JAL → `link_addr`=0x00400024 during HOLD.
  - JR with reg_target=0x00400200 and Jump also asserted → 0x00400200 (JR priority).
- Misaligned JR, reg_target=0x00400202:
  - With `FETCH_ALIGN_CHECK_EN` → `fetch_err`=1, `imem_req` stays 0, `pc` unchanged.
  - Without → fetch at 0x00400200.
- Reset mid-FETCH: `rst_n`=0 while `imem_req`=1, `imem_ready` pulses during reset → all outputs at reset values; `instr` stays 0.
